wts_channel_sequencer: RTL
==========================

# wts_channel_sequencer

Parametrised time-slot channel sequencer and mixer for the wave table sound core. It steps a channel index through `channels` slots and registers the selected channel sample, applying a per-channel mute. It accumulates one signed frame sum per full slot sweep. It sits between the per-channel wave generators and the DAC/output stage, replacing the fixed 5-way combinational channel select with a clocked, width- and channel-count-generic sequencer.

## Interface
Parameters:
- `bits`, 8, sample width per channel; signed two's complement
- `channels`, 5, number of channel slots; 1..16
- `ch_w`, derived (local), `channels>1 ? $clog2(channels) : 1`; index width

Ports:
- `clk`  in  1  system clock
- `nreset`  in  1  reset, synchronous, active-low
- `enable`  in  1  slot-advance strobe; one slot processed per cycle it is high
- `restart`  in  1  synchronous frame restart
- `mute`  in  `channels`  per-channel mute; bit k mutes channel k
- `reg_flat`  in  `channels*bits`  packed channel samples; channel k at `[k*bits +: bits]`
- `active`  out  `ch_w`  index of the slot processed on the next `enable`
- `result`  out  `bits`  registered sample of the last processed slot
- `result_valid`  out  1  one-cycle pulse: `result` updated
- `frame_end`  out  1  pulse with `result_valid` when the processed slot was `channels-1`
- `mix`  out  `bits+ch_w`  signed sum of one complete frame
- `mix_valid`  out  1  one-cycle pulse: `mix` updated

## Operation
- Reset (`nreset`=0 at a clk edge) clears all outputs and the accumulator: `active`=0, `result`=0, `result_valid`=0, `frame_end`=0, `mix`=0, `mix_valid`=0.
- Priority per cycle: reset > `restart` > `enable` > idle.
- `restart`=1: `active`←0 and accumulator←0. There are no valid pulses that cycle, and `result`/`mix` hold. `enable` is ignored in the same cycle.
- `enable`=1 with `active`=k:
  - sel = `mute[k]` ? 0 : `reg_flat[k]`
  - `result`←sel; `result_valid`←1
  - acc_next = (k==0 ? 0 : acc) + sign-extended sel, computed at width `bits+ch_w`; the sum cannot overflow
  - acc←acc_next
  - if k==`channels-1`: `mix`←acc_next, `mix_valid`←1, `frame_end`←1, `active`←0
  - otherwise `active`←k+1
- `enable`=0: `active`, `result`, `mix` and acc hold. All pulses are 0.
- `mute` and `reg_flat` are sampled only in the `enable` cycle. Changes between slots affect only slots not yet processed.
- `channels`=1: `active` is constant 0, and every `enable` produces `result_valid`, `frame_end` and `mix_valid` together, with `mix` = sign-extended sample.

## Timing
- Latency 1 cycle: the `enable` edge at cycle t yields `result`/pulses visible at t+1.
- Back-to-back `enable` gives one slot per cycle. A full frame takes `channels` enabled cycles, which need not be contiguous.
- `mix_valid` and `frame_end` always coincide, and both are subsets of `result_valid`.
- Reset or `restart` mid-frame discards the partial sum. No `mix_valid` is produced for that frame, and the next frame starts at slot 0.
- Pulses never stretch. Each is high exactly one cycle per qualifying `enable`.

## Structure
- Shared package `wts_pkg`: the `ch_w` derivation function (clog2 with min 1) and the maximum channel count constant (16).
- Sub-module `wts_slot_mux` #(bits, channels): a combinational N:1 select of `reg_flat` by index. An out-of-range index returns 0.
- Top level holds the slot counter, mute gate, accumulator and output registers.

## Test plan
- Reset: hold `nreset`=0 with `enable`=1 for 3 cycles → all outputs 0, no pulses; release → `active`=0.
- Full frame, defaults: samples 10,-20,30,-40,50 and `enable` held 5 cycles → `result` sequence 10,-20,30,-40,50. `frame_end` and `mix_valid` are high only on the 5th output, with `mix`=30, then `active`=0.
- Mute: same samples, `mute`=5'b00100 → slot 2 `result`=0, `mix`=0.
- Extremes: all samples -128 (bits=8, channels=5) → `mix`=-640 (11-bit 0x580); all +127 → `mix`=635.
- Gapped enable plus restart: enable slots 0,1, then idle 4 cycles → outputs hold and no pulses. `restart` with `enable`=1 → `active`=0 and no pulse. A subsequent full frame of all 1s → `mix`=5.
- `channels`=1, bits=12: sample -3 → every `enable` pulses all three strobes, with `mix`=-3 (13 bits).

Source files
------------

// File: rtl/wts_pkg.sv
// Shared definitions for the wave table sound channel sequencer.
// Holds the index-width helper and the channel count ceiling.
package wts_pkg;

    localparam int MAX_CHANNELS = 16;

    // Slot index width: clog2 of the channel count, never below one bit.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wts_slot_mux.sv
// Combinational N:1 channel sample select by slot index.
// Indices past the last channel read as zero.
module wts_slot_mux
    import wts_pkg::*;
#(
    parameter int bits     = 8,
    parameter int channels = 5
) (
    input  logic [channels*bits-1:0]       reg_flat,
    input  logic [ch_width(channels)-1:0]  idx,
    output logic [bits-1:0]                sample
);

    // Scan all slots; only an in-range match drives a non-zero sample.
    always_comb begin
        sample = '0;
        for (int k = 0; k < channels; k++) begin
            if (int'(idx) == k) begin
                sample = reg_flat[k*bits +: bits];
            end
        end
    end

endmodule

// File: rtl/wts_channel_sequencer.sv
// Time-slot channel sequencer: steps through slots, gates mutes,
// registers the selected sample and accumulates one frame mix.
module wts_channel_sequencer
    import wts_pkg::*;
#(
    parameter int bits     = 8,
    parameter int channels = 5
) (
    input  logic                                clk,
    input  logic                                nreset,
    input  logic                                enable,
    input  logic                                restart,
    input  logic [channels-1:0]                 mute,
    input  logic [channels*bits-1:0]            reg_flat,
    output logic [ch_width(channels)-1:0]       active,
    output logic [bits-1:0]                     result,
    output logic                                result_valid,
    output logic                                frame_end,
    output logic [bits+ch_width(channels)-1:0]  mix,
    output logic                                mix_valid
);

    localparam int ch_w = ch_width(channels);
    localparam int mw   = bits + ch_w;

    localparam logic [ch_w-1:0] LAST = ch_w'(channels - 1);
    localparam logic [ch_w-1:0] ONE  = ch_w'(1);

    logic [ch_w-1:0] r_active;
    logic [bits-1:0] r_result;
    logic            r_result_valid;
    logic            r_frame_end;
    logic [mw-1:0]   r_mix;
    logic            r_mix_valid;
    logic [mw-1:0]   r_acc;

    logic [bits-1:0] w_sample;
    logic            w_mute_bit;
    logic [bits-1:0] w_sel;
    logic [mw-1:0]   w_acc_base;
    logic [mw-1:0]   w_acc_next;
    logic            w_last;

    wts_slot_mux #(
        .bits     (bits),
        .channels (channels)
    ) u_mux (
        .reg_flat (reg_flat),
        .idx      (r_active),
        .sample   (w_sample)
    );

    // Mute bit of the current slot; out-of-range slots read unmuted.
    always_comb begin
        w_mute_bit = 1'b0;
        for (int k = 0; k < channels; k++) begin
            if (int'(r_active) == k) begin
                w_mute_bit = mute[k];
            end
        end
    end

    // Gate the sample and form the running sum; slot 0 starts fresh.
    always_comb begin
        w_sel      = w_mute_bit ? '0 : w_sample;
        w_acc_base = (r_active == '0) ? '0 : r_acc;
        w_acc_next = w_acc_base + {{ch_w{w_sel[bits-1]}}, w_sel};
        w_last     = (r_active == LAST);
    end

    // Slot counter, output registers and accumulator update.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_active       <= '0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_frame_end    <= 1'b0;
            r_mix          <= '0;
            r_mix_valid    <= 1'b0;
            r_acc          <= '0;
        end else begin
            r_result_valid <= 1'b0;
            r_frame_end    <= 1'b0;
            r_mix_valid    <= 1'b0;
            if (restart) begin
                r_active <= '0;
                r_acc    <= '0;
            end else if (enable) begin
                r_result       <= w_sel;
                r_result_valid <= 1'b1;
                r_acc          <= w_acc_next;
                if (w_last) begin
                    r_mix       <= w_acc_next;
                    r_mix_valid <= 1'b1;
                    r_frame_end <= 1'b1;
                    r_active    <= '0;
                end else begin
                    r_active <= r_active + ONE;
                end
            end
        end
    end

    assign active       = r_active;
    assign result       = r_result;
    assign result_valid = r_result_valid;
    assign frame_end    = r_frame_end;
    assign mix          = r_mix;
    assign mix_valid    = r_mix_valid;

endmodule
